sha3_256_ctrl: RTL and testbench



---
 rtl/sha3_256_ctrl.sv | 159 +++++++++++++++
 tb/tb_sha3_256_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sha3_256_ctrl.sv
// sha3_256_ctrl: sequencing controller for the SHA3-256 sponge datapath.
// It clears the sponge at message start, accepts 1088-bit rate blocks over
// valid/ready, strobes absorb and round-advance, tracks the round index and
// offers the digest over a valid/ready handshake once the final block's
// permutation is complete. No data passes through this block; every output
// is decoded from registered state only (Moore).
//
// Optional build macro SHA3_CTRL_PERF_EN adds perm_cnt, a saturating count
// of permutations completed since the last CLEAR.
module sha3_256_ctrl #(
    parameter int ROUNDS = 24,   // Keccak-p rounds per permutation (1..31)
    parameter int PIPE   = 2,    // clock cycles per round (1..4)
    parameter int CNT_W  = 16    // perm_cnt width (optional feature only)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             blk_valid,
    input  logic             blk_last,
    output logic             blk_ready,
    output logic             st_clear,
    output logic             st_absorb,
    output logic             rc_init,
    output logic             rnd_en,
    output logic [4:0]       rnd_idx,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic             busy
`ifdef SHA3_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perm_cnt
`endif
);

    localparam int               SUB_W    = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PIPE - 1);
    localparam logic [4:0]       RND_LAST = 5'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_BLK,
        ABSORB,
        ROUND,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [SUB_W-1:0] sub, sub_nxt;     // cycle within the current round
    logic [4:0]       rnd, rnd_nxt;     // round index, 0 outside ROUND
    logic             last, last_nxt;   // current block is the final one
    logic             rnd_fire;         // last sub-cycle of a round
    logic             perm_done;        // final round of a permutation

    assign rnd_fire  = (state == ROUND) && (sub == SUB_LAST);
    assign perm_done = rnd_fire && (rnd == RND_LAST);

    // State and counter registers; async reset forces IDLE so every
    // decoded strobe drops immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sub   <= '0;
            rnd   <= '0;
            last  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // the pre-edge values, independent of statement order.
            state <= state_nxt;
            sub   <= sub_nxt;
            rnd   <= rnd_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state, counter update and Moore output decode.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no
        // path through the case can leave one unassigned (no latches).
        state_nxt = state;
        sub_nxt   = sub;
        rnd_nxt   = rnd;
        last_nxt  = last;

        blk_ready = (state == WAIT_BLK);
        st_clear  = (state == CLEAR);
        st_absorb = (state == ABSORB);
        rc_init   = (state == ABSORB);
        rnd_en    = rnd_fire;
        rnd_idx   = (state == ROUND) ? rnd : 5'd0;
        dig_valid = (state == DONE);
        busy      = (state != IDLE);

        unique case (state)
            IDLE: begin
                last_nxt = 1'b0;
                if (start) state_nxt = CLEAR;
            end
            CLEAR: state_nxt = WAIT_BLK;
            WAIT_BLK: begin
                if (blk_valid) begin
                    last_nxt  = blk_last;
                    state_nxt = ABSORB;
                end
            end
            ABSORB: begin
                sub_nxt   = '0;
                rnd_nxt   = '0;
                state_nxt = ROUND;
            end
            ROUND: begin
                if (rnd_fire) begin
                    sub_nxt = '0;
                    if (perm_done) begin
                        rnd_nxt   = '0;
                        state_nxt = last ? DONE : WAIT_BLK;
                    end else begin
                        rnd_nxt = rnd + 5'd1;
                    end
                end else begin
                    sub_nxt = sub + SUB_W'(1);
                end
            end
            DONE: begin
                if (dig_ready) begin
                    last_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides every transition above, including start, block
        // accept and digest handshake in the same cycle.
        if (abort) begin
            state_nxt = IDLE;
            sub_nxt   = '0;
            rnd_nxt   = '0;
            last_nxt  = 1'b0;
        end
    end

`ifdef SHA3_CTRL_PERF_EN
    // Saturating permutation counter; zeroed at CLEAR and on abort so an
    // aborted message leaves every output at 0, otherwise held until the
    // next message starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_cnt <= '0;
        end else if (abort || state == CLEAR) begin
            perm_cnt <= '0;
        end else if (perm_done && (perm_cnt != {CNT_W{1'b1}})) begin
            perm_cnt <= perm_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sha3_256_ctrl.sv
// Directed bench for sha3_256_ctrl. Instance u_dut uses the default
// ROUNDS=24/PIPE=2 build, u_dut_p1 the PIPE=1 build. Cycle 0 is the cycle
// in which start is presented; outputs are sampled 1 time unit after each
// rising edge. Expected strobe timings are derived from the cycle formulas
// of a single-block message (CLEAR@1, WAIT_BLK@2, ABSORB@3, ROUND from 4).
module tb_sha3_256_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default-build instance signals.
    logic       start, abort, blk_valid, blk_last, dig_ready;
    logic       blk_ready, st_clear, st_absorb, rc_init, rnd_en, dig_valid, busy;
    logic [4:0] rnd_idx;

    // PIPE=1 instance signals.
    logic       start_b, abort_b, blk_valid_b, blk_last_b, dig_ready_b;
    logic       blk_ready_b, st_clear_b, st_absorb_b, rc_init_b, rnd_en_b, dig_valid_b, busy_b;
    logic [4:0] rnd_idx_b;

`ifdef SHA3_CTRL_PERF_EN
    logic [15:0] perm_cnt, perm_cnt_b;
`endif

    sha3_256_ctrl #(.ROUNDS(24), .PIPE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
        .st_clear(st_clear), .st_absorb(st_absorb), .rc_init(rc_init),
        .rnd_en(rnd_en), .rnd_idx(rnd_idx), .dig_valid(dig_valid),
        .dig_ready(dig_ready), .busy(busy)
`ifdef SHA3_CTRL_PERF_EN
        , .perm_cnt(perm_cnt)
`endif
    );

    sha3_256_ctrl #(.ROUNDS(24), .PIPE(1)) u_dut_p1 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .blk_valid(blk_valid_b), .blk_last(blk_last_b), .blk_ready(blk_ready_b),
        .st_clear(st_clear_b), .st_absorb(st_absorb_b), .rc_init(rc_init_b),
        .rnd_en(rnd_en_b), .rnd_idx(rnd_idx_b), .dig_valid(dig_valid_b),
        .dig_ready(dig_ready_b), .busy(busy_b)
`ifdef SHA3_CTRL_PERF_EN
        , .perm_cnt(perm_cnt_b)
`endif
    );

    // Packed view: {busy, st_clear, blk_ready, st_absorb, rc_init, rnd_en, dig_valid, rnd_idx}
    logic [11:0] vec_a, vec_b;
    assign vec_a = {busy, st_clear, blk_ready, st_absorb, rc_init, rnd_en, dig_valid, rnd_idx};
    assign vec_b = {busy_b, st_clear_b, blk_ready_b, st_absorb_b, rc_init_b, rnd_en_b,
                    dig_valid_b, rnd_idx_b};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected output vector of a single-block message with start at cycle 0,
    // PIPE p, ROUNDS 24, and dig_ready first high in cycle dr.
    function automatic logic [11:0] exp_single(input int c, input int p, input int dr);
        logic [11:0] v;
        int          rend;
        v    = '0;
        rend = 3 + 24 * p;
        if (c >= 1 && c <= dr) v[11] = 1'b1;
        if (c == 1) v[10] = 1'b1;
        if (c == 2) v[9] = 1'b1;
        if (c == 3) begin
            v[8] = 1'b1;
            v[7] = 1'b1;
        end
        if (c >= 4 && c <= rend) begin
            v[4:0] = 5'((c - 4) / p);
            if ((c - 4) % p == p - 1) v[6] = 1'b1;
        end
        if (c > rend && c <= dr) v[5] = 1'b1;
        return v;
    endfunction

    task automatic clear_inputs();
        start = 0; abort = 0; blk_valid = 0; blk_last = 0; dig_ready = 0;
        start_b = 0; abort_b = 0; blk_valid_b = 0; blk_last_b = 0; dig_ready_b = 0;
    endtask

    initial begin
        int n_rnd, n_abs, n_reent, dv_first, bad;
        logic prev_ready;

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", vec_a, 12'h000);
        check("reset_b", vec_b, 12'h000);
        rst_n = 1'b1;
        next_cycle();
        check("idle_a", vec_a, 12'h000);

        // ---- single block, start/blk_valid during ROUND must be ignored ----
        cyc = 0; start = 1; blk_valid = 1; blk_last = 1;
        check("t1_vec", vec_a, exp_single(0, 2, 55));
        n_rnd = 0;
        for (int i = 1; i <= 60; i++) begin
            next_cycle();
            start     = (cyc == 10) || (cyc == 30);
            dig_ready = (cyc == 55);
            check("t1_vec", vec_a, exp_single(cyc, 2, 55));
            if (rnd_en) n_rnd++;
        end
        check("t1_rnd_cnt", n_rnd, 24);
        clear_inputs();
        next_cycle();

        // ---- three blocks, 3-cycle upstream stall before block 2 ----
        cyc = 0; start = 1; blk_valid = 1; blk_last = 0;
        n_rnd = 0; n_abs = 0; n_reent = 0; dv_first = -1; bad = 0; prev_ready = 0;
        for (int i = 1; i <= 160; i++) begin
            next_cycle();
            start     = 0;
            blk_valid = !(cyc >= 52 && cyc <= 54);
            blk_last  = (cyc >= 105);
            dig_ready = (cyc >= 155);
            if (rnd_en) n_rnd++;
            if (st_absorb) n_abs++;
            if (blk_ready && !prev_ready && n_abs > 0) n_reent++;
            prev_ready = blk_ready;
            if (dig_valid && dv_first < 0) dv_first = cyc;
            if (blk_ready && dig_valid) bad++;
        end
        check("t2_absorbs", n_abs, 3);
        check("t2_rnd_cnt", n_rnd, 72);
        check("t2_reenter", n_reent, 2);
        check("t2_dv_cycle", dv_first, 155);
        check("t2_excl", bad, 0);
        check("t2_idle", vec_a, 12'h000);
`ifdef SHA3_CTRL_PERF_EN
        check("t2_perm_cnt", perm_cnt, 3);
`endif
        clear_inputs();
        next_cycle();

        // ---- abort with same-cycle start, then a clean restart ----
        cyc = 0; start = 1; blk_valid = 1; blk_last = 1;
        for (int i = 1; i <= 26; i++) begin
            next_cycle();
            start = (cyc == 20) || (cyc == 22);
            abort = (cyc == 20) || (cyc == 24);
            if (cyc == 20) check("t3_pre_abort", vec_a, 12'h808);
            if (cyc == 21) check("t3_aborted", vec_a, 12'h000);
            if (cyc == 23) check("t3_reclear", vec_a, 12'hC00);
            if (cyc == 24) check("t3_wait_blk", vec_a, 12'hA00);
            if (cyc == 25) check("t3_abort_wb", vec_a, 12'h000);
            if (cyc == 26) check("t3_stay_idle", vec_a, 12'h000);
        end
        clear_inputs();
        next_cycle();

        // ---- asynchronous reset mid-ROUND ----
        cyc = 0; start = 1; blk_valid = 1; blk_last = 1;
        while (cyc < 30) begin
            next_cycle();
            start = 0;
        end
        check("t4_pre_rst", vec_a, exp_single(30, 2, 55));
        rst_n = 1'b0;
        #1;
        check("t4_rst_now", vec_a, 12'h000);
        next_cycle();
        check("t4_rst_hold", vec_a, 12'h000);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            next_cycle();
            dig_ready = 1;
            if (busy || rnd_en || dig_valid || st_absorb) bad++;
        end
        check("t4_quiet", bad, 0);
        clear_inputs();
        next_cycle();

        // ---- PIPE=1 build, dig_ready already high ----
        cyc = 0; start_b = 1; blk_valid_b = 1; blk_last_b = 1; dig_ready_b = 1;
        check("t5_vec", vec_b, exp_single(0, 1, 28));
        n_rnd = 0;
        for (int i = 1; i <= 32; i++) begin
            next_cycle();
            start_b = 0;
            check("t5_vec", vec_b, exp_single(cyc, 1, 28));
            if (rnd_en_b) n_rnd++;
        end
        check("t5_rnd_cnt", n_rnd, 24);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
